// File: rtl/root_if.sv
// root_if: start/busy handshake and operand/result bus for root_unit.
interface root_if #(parameter int WIDTH = 16);
  localparam int OUT_W = (WIDTH + 1) / 2;
  logic             start;
  logic             mode_i;
  logic [WIDTH-1:0] x_in;
  logic [OUT_W-1:0] y_out;
  logic [WIDTH-1:0] rem_out;
  logic             busy_o;
  logic             done_o;
  modport master (output start, mode_i, x_in, input y_out, rem_out, busy_o, done_o);
  modport slave  (input start, mode_i, x_in, output y_out, rem_out, busy_o, done_o);
endinterface

// File: rtl/root_unit.sv
// root_unit: sequential digit-by-digit cube/square integer root with remainder.
// Square-root mode is compiled in only when ROOT_UNIT_SQRT_EN is defined.
module root_unit #(parameter int WIDTH = 16) (
  input logic   clk,
  input logic   rst,
  root_if.slave io
);
  localparam int OUT_W = (WIDTH + 1) / 2;
  localparam int N3 = (WIDTH + 2) / 3;
  localparam int N2 = (WIDTH + 1) / 2;
  localparam int SW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(OUT_W + 1);
  localparam logic [SW-1:0] S3 = SW'(3 * (N3 - 1));
  localparam logic [SW-1:0] S2 = SW'(2 * (N2 - 1));
  typedef enum logic [2:0] {IDLE, SHIFT, MUL, TRIPLE, CMP, DONE} state_t;
  state_t             state;
  logic [WIDTH-1:0]   x;
  logic [OUT_W-1:0]   y, y_sh, m;
  logic [SW-1:0]      s;
  logic [CW-1:0]      mc;
  logic [2*OUT_W-1:0] p, a;
  logic [2*WIDTH-1:0] b, b_cmp, b_tri;
  logic               mode, mode_in, ge;
  assign y_sh  = y << 1;
  assign b_tri = ((2*WIDTH)'({p, 1'b0}) + (2*WIDTH)'(p) + (2*WIDTH)'(1)) << s;
  assign ge    = {{WIDTH{1'b0}}, x} >= b_cmp;
`ifdef ROOT_UNIT_SQRT_EN
  assign mode_in = io.mode_i;
  assign b_cmp   = mode ? ((2*WIDTH)'({y, 1'b1}) << s) : b;
  always_ff @(posedge clk or negedge rst)
    if (!rst) mode <= 1'b0;
    else if (state == IDLE && io.start) mode <= mode_in;
`else
  assign mode_in = 1'b0;
  assign mode    = 1'b0;
  assign b_cmp   = b;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      s          <= '0;
      mc         <= '0;
      p          <= '0;
      a          <= '0;
      m          <= '0;
      b          <= '0;
      io.y_out   <= '0;
      io.rem_out <= '0;
      io.busy_o  <= 1'b0;
      io.done_o  <= 1'b0;
    end else begin
      io.done_o <= 1'b0;
      case (state)
        IDLE: if (io.start) begin
          x         <= io.x_in;
          y         <= '0;
          s         <= mode_in ? S2 : S3;
          io.busy_o <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          // y_sh is even, so y_sh|1 equals y_sh+1 without widening
          y     <= y_sh;
          p     <= '0;
          a     <= (2*OUT_W)'(y_sh);
          m     <= y_sh | OUT_W'(1);
          mc    <= CW'(OUT_W - 1);
          state <= mode ? CMP : MUL;
        end
        MUL: begin
          if (m[0]) p <= p + a;
          a  <= a << 1;
          m  <= m >> 1;
          mc <= mc - CW'(1);
          if (mc == '0) state <= TRIPLE;
        end
        TRIPLE: begin
          b     <= b_tri;
          state <= CMP;
        end
        CMP: begin
          if (ge) begin
            x <= x - b_cmp[WIDTH-1:0];
            y <= y + OUT_W'(1);
          end
          if (s == '0) state <= DONE;
          else begin
            s     <= s - (mode ? SW'(2) : SW'(3));
            state <= SHIFT;
          end
        end
        DONE: begin
          io.y_out   <= y;
          io.rem_out <= x;
          io.busy_o  <= 1'b0;
          io.done_o  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_root_unit.sv
// tb_root_unit: table, random and sequence checks of root_unit against an arithmetic root model.
module tb_root_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  root_if #(.WIDTH(16)) io();
  root_unit #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic        m;
    longint      y;
    longint      r;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit eff(input bit m);
`ifdef ROOT_UNIT_SQRT_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint exp_lat(input bit m);
    return eff(m) ? 2 * 8 + 1 : 6 * (8 + 3) + 1;
  endfunction

  task automatic model(input longint xv, input bit sq, output longint y, output longint r);
    y = 0;
    while (sq ? (y + 1) * (y + 1) <= xv : (y + 1) * (y + 1) * (y + 1) <= xv) y++;
    r = xv - (sq ? y * y : y * y * y);
  endtask

  task automatic run(input logic [15:0] xv, input logic mv, output longint y, output longint r, output longint lat);
    @(negedge clk);
    io.start = 1'b1;
    io.x_in = xv;
    io.mode_i = mv;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.x_in = 16'($urandom);
    io.mode_i = 1'($urandom);
    chk("busy_after_start", longint'(io.busy_o), 1);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (io.done_o) begin
        lat = n;
        break;
      end
    end
    y = longint'(io.y_out);
    r = longint'(io.rem_out);
    chk("busy_at_done", longint'(io.busy_o), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", longint'(io.done_o), 0);
  endtask

  initial begin
    longint y, r, lat, ey, er;
    int extra;
    io.start = 1'b0;
    io.mode_i = 1'b0;
    io.x_in = '0;
    tbl[0] = '{16'd0,     1'b0, 0,  0};
    tbl[1] = '{16'd1,     1'b0, 1,  0};
    tbl[2] = '{16'd7,     1'b0, 1,  6};
    tbl[3] = '{16'd8,     1'b0, 2,  0};
    tbl[4] = '{16'd65535, 1'b0, 40, 1535};
    tbl[5] = '{16'd63999, 1'b0, 39, 4680};
`ifdef ROOT_UNIT_SQRT_EN
    tbl[6] = '{16'd65535, 1'b1, 255, 510};
    tbl[7] = '{16'd1000,  1'b1, 31,  39};
`else
    tbl[6] = '{16'd65535, 1'b1, 40, 1535};
    tbl[7] = '{16'd1000,  1'b1, 10, 0};
`endif
    #12;
    chk("reset_y", longint'(io.y_out), 0);
    chk("reset_rem", longint'(io.rem_out), 0);
    chk("reset_busy", longint'(io.busy_o), 0);
    chk("reset_done", longint'(io.done_o), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].x, tbl[i].m, y, r, lat);
      chk($sformatf("tbl%0d_y", i), y, tbl[i].y);
      chk($sformatf("tbl%0d_rem", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].m));
    end

    for (int i = 0; i <= 40; i++) begin
      run(16'(i * i * i), 1'b0, y, r, lat);
      chk($sformatf("cube%0d_y", i), y, i);
      chk($sformatf("cube%0d_rem", i), r, 0);
      chk($sformatf("cube%0d_lat", i), lat, exp_lat(1'b0));
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] xv;
      logic mv;
      xv = 16'($urandom);
      mv = 1'($urandom);
      model(longint'(xv), eff(mv), ey, er);
      run(xv, mv, y, r, lat);
      chk($sformatf("rnd%0d_y x=%0d m=%0d", i, xv, mv), y, ey);
      chk($sformatf("rnd%0d_rem x=%0d m=%0d", i, xv, mv), r, er);
      chk($sformatf("rnd%0d_lat", i), lat, exp_lat(mv));
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    io.start = 1'b1;
    io.x_in = 16'd64;
    io.mode_i = 1'b0;
    @(negedge clk);
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    io.start = 1'b1;
    io.x_in = 16'd27;
    @(negedge clk);
    io.start = 1'b0;
    extra = 0;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk);
      #1;
      if (io.done_o) begin
        extra++;
        if (extra == 1) begin
          chk("busy_start_y", longint'(io.y_out), 4);
          chk("busy_start_rem", longint'(io.rem_out), 0);
        end
      end
    end
    chk("busy_start_completions", extra, 1);

    // asynchronous reset in the middle of the multiply phase
    @(negedge clk);
    io.start = 1'b1;
    io.x_in = 16'd1000;
    io.mode_i = 1'b0;
    @(negedge clk);
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_y", longint'(io.y_out), 0);
    chk("rst_mid_rem", longint'(io.rem_out), 0);
    chk("rst_mid_busy", longint'(io.busy_o), 0);
    chk("rst_mid_done", longint'(io.done_o), 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (io.done_o) extra++;
    end
    chk("rst_abort_no_done", extra, 0);
    run(16'd8, 1'b0, y, r, lat);
    chk("post_rst_y", y, 2);
    chk("post_rst_rem", r, 0);
    chk("post_rst_lat", lat, exp_lat(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
